// File: rtl/id_ex_pipe_stage_if.sv
// Valid/ready bus carrying one ID/EX entry (control + data bundles).
interface id_ex_pipe_stage_if #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned DATA_W = 192
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  // Producer side of the bus.
  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  // Consumer side of the bus.
  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// Elastic ID/EX pipeline stage: optional skid buffer, flush, and
// saturating stall/flush event counters.
module id_ex_pipe_stage #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned DATA_W = 192,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  id_ex_pipe_stage_if.slave   in_if,
  id_ex_pipe_stage_if.master  out_if,
  input  logic                flush,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  logic              out_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_if.valid & in_if.ready;
  assign out_xfer = out_valid & out_if.ready;

  assign out_if.valid = out_valid;
  // Bubbles never leak stale control into execute.
  assign out_if.ctrl  = out_valid ? head_ctrl : '0;

  if (SKID == 0) begin : g_single
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign in_if.ready = ~valid_q | out_if.ready;
    assign out_valid   = valid_q;
    assign head_ctrl   = ctrl_q;
    assign out_if.data = data_q;

    // Load on input transfer, drain on lone output transfer, kill on flush.
    always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (in_xfer) begin
        valid_d = 1'b1;
        ctrl_d  = in_if.ctrl;
        data_d  = in_if.data;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
      if (flush) valid_d = 1'b0;
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
      if (!RESET) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        data_q  <= data_d;
      end
    end
  end else begin : g_skid
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;

    assign in_if.ready = rdy_q;
    assign out_valid   = (state_q != StEmpty);
    assign head_ctrl   = main_ctrl_q;
    assign out_if.data = main_data_q;

    // Occupancy FSM; main slot is always the head, skid slot the second entry.
    always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d     = StOne;
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end else if (in_xfer) begin
            state_d     = StTwo;
            skid_ctrl_d = in_if.ctrl;
            skid_data_d = in_if.data;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_xfer) begin
            state_d     = StOne;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
      if (flush) state_d = StEmpty;
      // Ready is precomputed so in_ready comes straight from a flop.
      rdy_d = (state_d != StTwo);
    end

    // Skid-buffer state with synchronous active-low reset.
    always_ff @(posedge CLK) begin
      if (!RESET) begin
        state_q     <= StEmpty;
        rdy_q       <= 1'b1;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        state_q     <= state_d;
        rdy_q       <= rdy_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
      end
    end
  end

  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // Saturating event counters; clear wins over increment.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (out_valid && !out_if.ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (flush && out_valid && (flush_q != '1))         flush_d = flush_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Drives one stimulus stream into a SKID=0 and a SKID=1 stage and checks both
// against a queue-based reference model.
module tb_id_ex_pipe_stage;
  localparam int unsigned CW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned CNW = 4;
  localparam int          SAT = 15;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic clr_cnt = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_pipe_stage_if #(.CTRL_W(CW), .DATA_W(DW)) in_if0 ();
  id_ex_pipe_stage_if #(.CTRL_W(CW), .DATA_W(DW)) out_if0 ();
  id_ex_pipe_stage_if #(.CTRL_W(CW), .DATA_W(DW)) in_if1 ();
  id_ex_pipe_stage_if #(.CTRL_W(CW), .DATA_W(DW)) out_if1 ();
  logic [CNW-1:0] sc0, fc0, sc1, fc1;

  assign in_if0.valid  = in_valid;
  assign in_if0.ctrl   = in_ctrl;
  assign in_if0.data   = in_data;
  assign out_if0.ready = out_ready;
  assign in_if1.valid  = in_valid;
  assign in_if1.ctrl   = in_ctrl;
  assign in_if1.data   = in_data;
  assign out_if1.ready = out_ready;

  id_ex_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(CNW)) dut0 (
    .CLK(CLK), .RESET(RESET), .in_if(in_if0), .out_if(out_if0),
    .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  id_ex_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(CNW)) dut1 (
    .CLK(CLK), .RESET(RESET), .in_if(in_if1), .out_if(out_if1),
    .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  // Reference model per stage: queue of expected entries {ctrl, data}.
  logic [CW+DW-1:0] sb [2][$];
  int exp_sc [2];
  int exp_fc [2];
  bit data_zero [2];

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s skid=%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic step(input int k, input logic v, input logic r, input logic [CW-1:0] c,
                      input logic [DW-1:0] d, input logic [CNW-1:0] sc,
                      input logic [CNW-1:0] fc);
    logic [CW+DW-1:0] head;
    bit ev, er, ix, ox;
    ev = (sb[k].size() != 0);
    // Capacity 1 with pass-through ready, or capacity 2 with ready from occupancy.
    er = (k == 0) ? (!ev || out_ready) : (sb[k].size() < 2);
    chk("out_valid", k, 64'(v), 64'(ev));
    chk("in_ready", k, 64'(r), 64'(er));
    if (ev) begin
      head = sb[k][0];
      chk("out_ctrl", k, 64'(c), 64'(head[CW+DW-1:DW]));
      chk("out_data", k, 64'(d), 64'(head[DW-1:0]));
    end else begin
      chk("bubble_ctrl", k, 64'(c), 64'd0);
      if (data_zero[k]) chk("reset_data", k, 64'(d), 64'd0);
    end
    chk("stall_cnt", k, 64'(sc), 64'(exp_sc[k]));
    chk("flush_cnt", k, 64'(fc), 64'(exp_fc[k]));

    // Advance the model across the coming edge.
    if (!RESET) begin
      sb[k].delete();
      exp_sc[k] = 0;
      exp_fc[k] = 0;
      data_zero[k] = 1'b1;
    end else begin
      ix = in_valid && er;
      ox = ev && out_ready;
      if (clr_cnt) begin
        exp_sc[k] = 0;
        exp_fc[k] = 0;
      end else begin
        if (ev && !out_ready && exp_sc[k] < SAT) exp_sc[k]++;
        if (flush && ev && exp_fc[k] < SAT) exp_fc[k]++;
      end
      if (ox) void'(sb[k].pop_front());
      if (flush) sb[k].delete();
      else if (ix) sb[k].push_back({in_ctrl, in_data});
      if (ix) data_zero[k] = 1'b0;
    end
  endtask

  // Monitor: compare both stages mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    step(0, out_if0.valid, in_if0.ready, out_if0.ctrl, out_if0.data, sc0, fc0);
    step(1, out_if1.valid, in_if1.ready, out_if1.ctrl, out_if1.data, sc1, fc1);
  end

  task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic ordy, input logic fl, input logic cl, input logic rs);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = cl;
    RESET     = rs;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      exp_sc[k] = 0;
      exp_fc[k] = 0;
      data_zero[k] = 1'b1;
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    // Single entry, one-cycle latency.
    cyc(1, 32'h1, 64'hA, 1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 1);
    // Back-pressure: A, B, then C held until space opens.
    cyc(1, 32'h2, 64'hA0, 0, 0, 0, 1);
    cyc(1, 32'h3, 64'hB0, 0, 0, 0, 1);
    repeat (4) cyc(1, 32'h4, 64'hC0, 0, 0, 0, 1);
    repeat (2) cyc(1, 32'h4, 64'hC0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 1);
    // Full-rate stream of 8.
    cyc(0, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(1, 32'h10 + i, 64'(i) + 64'h100, 1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 1);
    // Fill, then flush while D is offered.
    cyc(1, 32'h5, 64'h50, 0, 0, 0, 1);
    cyc(1, 32'h6, 64'h60, 0, 0, 0, 1);
    cyc(1, 32'h7, 64'hD0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Flush while empty, then flush alongside an output transfer.
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(1, 32'h8, 64'h80, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    // Long stall to saturate, then clear under stall.
    cyc(1, 32'h9, 64'h90, 0, 0, 0, 1);
    repeat (20) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Reset while full.
    cyc(1, 32'hB, 64'hB0, 0, 0, 0, 1);
    cyc(1, 32'hC, 64'hC1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3) != 0), $urandom, {$urandom, $urandom},
          ($urandom_range(3) != 0), ($urandom_range(15) == 0),
          ($urandom_range(31) == 0), ($urandom_range(99) != 0));
    end
    repeat (4) cyc(0, 0, 0, 1, 0, 0, 1);
    @(posedge CLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register.
- Carries a control bundle and a data bundle of configurable widths between decode and execute.
- Uses a valid/ready handshake, with an optional two-entry skid buffer so that in_ready is registered.
- Supports synchronous flush (bubble insertion) and keeps saturating stall/flush event counters for performance debug.

Parameters:
- CTRL_W, 32: control bundle width; reads as zero whenever the stage holds a bubble.
- DATA_W, 192: data bundle width (operands, PC, immediates, RegDst).
- SKID, 1: 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready.
- CNT_W, 16: width of each event counter.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept.
- in_ctrl  in  CTRL_W  control bundle in.
- in_data  in  DATA_W  data bundle in.
- flush  in  1  kill all held entries and any entry offered this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control; zero when out_valid=0.
- out_data  out  DATA_W  head data.
- clr_cnt  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry.

Behaviour:
- Only CLK exists. RESET is synchronous and active-low, sampled at the CLK rising edge; while RESET=0 every other input is ignored.
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, flush_cnt=0.
  - Skid entry invalid and cleared.
  - in_ready=1 in the first cycle after RESET deasserts, for both SKID values.
- Transfers:
  - Input transfer: in_valid & in_ready at the edge.
  - Output transfer: out_valid & out_ready at the edge.
  - Entries leave in arrival order; no entry is duplicated or dropped except by flush.
- Latency: an entry accepted into an empty stage appears at out_valid/out_ctrl/out_data in the next cycle (1 cycle). Full throughput is 1 entry/cycle when out_ready is held at 1.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - The register loads on input transfer and holds otherwise.
  - An output transfer with no simultaneous input transfer clears valid.
- SKID=1, state machine {EMPTY, ONE, TWO}; in_ready = (state != TWO), driven from a flop:
  - EMPTY: input transfer -> ONE.
  - ONE: input and output transfer together -> ONE, main reloads with the new entry. Input only -> TWO, new entry goes to the skid slot. Output only -> EMPTY.
  - TWO: output transfer -> ONE, skid entry moves to main. No input transfer is possible in TWO.
- Flush:
  - Highest priority after reset.
  - At the edge: all entries become invalid and state -> EMPTY.
  - An entry offered in the flush cycle is treated as consumed (in_ready is unaffected) and is discarded.
  - An output handshake in the flush cycle completes normally, since downstream sampled it.
  - The next cycle has out_valid=0, out_ctrl=0 and in_ready=1.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0. out_data is held but carries no meaning.
- Counters:
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt overrides any increment in the same cycle; the counter reads 0 next cycle.
  - stall_cnt increments when out_valid & ~out_ready.
  - flush_cnt increments when flush=1 and at least one entry is valid, including the entry being output that cycle.
  - Counters are unaffected by flush other than through the increment above.
- Reset while full (TWO) or mid-flush: both entries are discarded; all reset values hold next cycle.

Test Plan:
- Reset, then offer A (ctrl=0x1, data=0xA) with out_ready=1 -> out_valid=1 with A one cycle later; in_ready stays 1 for SKID=0 and SKID=1.
- SKID=1, out_ready=0, offer A,B,C on consecutive cycles -> A and B accepted, in_ready=0 from the cycle after B; stall_cnt increments every cycle. Raise out_ready -> out order A,B, then C is accepted.
- Stream 8 entries with out_ready=1 every cycle -> 8 outputs in order on consecutive cycles; stall_cnt=0.
- In TWO, assert flush while in_valid=1 with D -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1; D never appears.
- Flush with the stage empty -> flush_cnt unchanged. Flush with out_valid=1, out_ready=1 -> that entry counted as output; flush_cnt+1.
- CNT_W=4, hold a stall for 20 cycles -> stall_cnt saturates at 15. Assert clr_cnt with a stall active -> stall_cnt=0 next cycle. Pull RESET low while in TWO -> all outputs 0, state EMPTY.
